precedence_sequencer: RTL and testbench

Parametrised operator-precedence sequencer for the calculator controller. It accepts one operator token at a time and compares it against the top of the operator stack using a parameter-defined precedence table with per-operator associativity. It then issues a sequence of reduce requests to the ALU side and stack pops/pushes until the token can be placed. Parentheses and end-of-expression flush are handled internally, replacing the single combinational compare-select step with a self-sequencing shunting-yard loop.

---
 rtl/precedence_sequencer.sv | 118 +++++++++++
 tb/tb_precedence_sequencer.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/precedence_sequencer.sv
// rtl/precedence_sequencer.sv - shunting-yard operator precedence sequencer
module precedence_sequencer #(
  parameter int                             OP_W        = 3,
  parameter int                             LVL_W       = 2,
  parameter logic [(2**OP_W)*LVL_W-1:0]     PREC_TABLE  = 16'h03A5,
  parameter logic [(2**OP_W)-1:0]           RASSOC_MASK = 8'h10,
  parameter logic [OP_W-1:0]                OP_LP       = 3'd5,
  parameter logic [OP_W-1:0]                OP_RP       = 3'd6,
  parameter logic [OP_W-1:0]                OP_END      = 3'd7,
  parameter int                             CNT_W       = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_op,
  input  logic [OP_W-1:0]  op_data,
  input  logic             op_empty,
  input  logic             op_full,
  output logic             op_push,
  output logic [OP_W-1:0]  op_wdata,
  output logic             op_pop,
  output logic             rd_valid,
  output logic [OP_W-1:0]  rd_op,
  input  logic             rd_ready,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] red_cnt
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COMPARE = 3'd1,
    S_REDUCE  = 3'd2,
    S_PUSH    = 3'd3,
    S_DONE    = 3'd4,
    S_ERR     = 3'd5
  } state_t;

  state_t          state;
  state_t          next_state;
  logic [OP_W-1:0] cur_op;

  function automatic logic [LVL_W-1:0] lvl(input logic [OP_W-1:0] code);
    return PREC_TABLE[code*LVL_W +: LVL_W];
  endfunction

  // Stack top outranks the incoming operator (ties reduce only when left-associative)
  logic top_wins;
  always_comb begin
    top_wins = (lvl(op_data) > lvl(cur_op)) ||
               ((lvl(op_data) == lvl(cur_op)) && !RASSOC_MASK[cur_op]);
  end

  // State register
  always_ff @(posedge Clock) begin
    if (Reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // Next-state decode: one shunting-yard decision per COMPARE cycle
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:    if (in_valid) next_state = S_COMPARE;
      S_COMPARE: begin
        if (cur_op == OP_LP) begin
          next_state = op_full ? S_ERR : S_PUSH;
        end else if (cur_op == OP_RP) begin
          if (op_empty)              next_state = S_ERR;
          else if (op_data == OP_LP) next_state = S_IDLE;
          else                       next_state = S_REDUCE;
        end else if (cur_op == OP_END) begin
          if (op_empty)              next_state = S_DONE;
          else if (op_data == OP_LP) next_state = S_ERR;
          else                       next_state = S_REDUCE;
        end else if (op_empty || (op_data == OP_LP) || !top_wins) begin
          next_state = op_full ? S_ERR : S_PUSH;
        end else begin
          next_state = S_REDUCE;
        end
      end
      S_REDUCE:  if (rd_ready) next_state = S_COMPARE;
      S_PUSH:    next_state = S_IDLE;
      S_DONE:    next_state = S_IDLE;
      S_ERR:     next_state = S_ERR;
      default:   next_state = S_IDLE;
    endcase
  end

  // Outputs decoded from state and registers only (in_valid never reaches in_ready)
  always_comb begin
    in_ready = (state == S_IDLE);
    rd_valid = (state == S_REDUCE);
    op_push  = (state == S_PUSH);
    op_wdata = cur_op;
    done     = (state == S_DONE);
    err      = (state == S_ERR);
    // A matching left paren is discarded straight from COMPARE without a reduce
    op_pop   = ((state == S_REDUCE) && rd_ready) ||
               ((state == S_COMPARE) && (cur_op == OP_RP) && !op_empty && (op_data == OP_LP));
  end

  // Token latch, reduce operator latch and saturating reduce counter
  always_ff @(posedge Clock) begin
    if (Reset) begin
      cur_op  <= '0;
      rd_op   <= '0;
      red_cnt <= '0;
    end else begin
      if ((state == S_IDLE) && in_valid) cur_op <= in_op;
      if ((state == S_COMPARE) && (next_state == S_REDUCE)) rd_op <= op_data;
      if ((state == S_REDUCE) && rd_ready && (red_cnt != '1)) red_cnt <= red_cnt + 1'b1;
      if (state == S_DONE) red_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_precedence_sequencer.sv
// tb/tb_precedence_sequencer.sv - scoreboard bench for precedence_sequencer
module tb_precedence_sequencer;

  localparam logic [2:0] AD = 3'd0, SB = 3'd1, ML = 3'd2, DV = 3'd3, PW = 3'd4;
  localparam logic [2:0] LP = 3'd5, RP = 3'd6, EN = 3'd7;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] in_op = 3'd0;
  logic [2:0] op_data;
  logic       op_empty;
  logic       op_full;
  logic       op_push;
  logic [2:0] op_wdata;
  logic       op_pop;
  logic       rd_valid;
  logic [2:0] rd_op;
  logic       rd_ready = 1'b1;
  logic       done;
  logic       err;
  logic [7:0] red_cnt;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int last_push_cyc = 0;
  int obs_pops = 0;

  logic [2:0] exp_push[$];
  logic [2:0] exp_rd[$];
  logic [7:0] exp_done[$];

  always #5 Clock = ~Clock;

  precedence_sequencer dut (
    .Clock(Clock), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .op_data(op_data), .op_empty(op_empty), .op_full(op_full), .op_push(op_push),
    .op_wdata(op_wdata), .op_pop(op_pop), .rd_valid(rd_valid), .rd_op(rd_op),
    .rd_ready(rd_ready), .done(done), .err(err), .red_cnt(red_cnt)
  );

  // Operator stack model: updates at the edge after op_push/op_pop
  logic [2:0] mem[0:7];
  logic [3:0] sp;
  logic       stk_clr = 1'b1;
  logic       force_full = 1'b0;

  always @(posedge Clock) begin
    cyc <= cyc + 1;
    if (stk_clr) sp <= 4'd0;
    else if (op_pop && sp != 4'd0) sp <= sp - 4'd1;
    else if (op_push && sp != 4'd8) begin
      mem[sp[2:0]] <= op_wdata;
      sp <= sp + 4'd1;
    end
  end

  assign op_data  = (sp != 4'd0) ? mem[3'(sp - 4'd1)] : 3'd0;
  assign op_empty = (sp == 4'd0);
  assign op_full  = force_full || (sp == 4'd8);

  // Scoreboard: pop the expected entry whenever the DUT produces an output event
  logic [2:0] e_op;
  logic [7:0] e_cnt;
  always @(negedge Clock) begin
    if (op_pop) obs_pops++;
    if (op_push) begin
      last_push_cyc = cyc;
      checks++;
      if (exp_push.size() == 0) begin
        errors++;
        $display("FAIL push_unexpected: got op_wdata=%0d, required no push", op_wdata);
      end else begin
        e_op = exp_push.pop_front();
        if (op_wdata !== e_op) begin
          errors++;
          $display("FAIL push_data: got %0d, required %0d", op_wdata, e_op);
        end
      end
    end
    if (rd_valid && rd_ready) begin
      checks++;
      if (exp_rd.size() == 0) begin
        errors++;
        $display("FAIL reduce_unexpected: got rd_op=%0d, required no reduce", rd_op);
      end else begin
        e_op = exp_rd.pop_front();
        if (rd_op !== e_op) begin
          errors++;
          $display("FAIL reduce_op: got %0d, required %0d", rd_op, e_op);
        end
      end
    end
    if (done) begin
      checks++;
      if (exp_done.size() == 0) begin
        errors++;
        $display("FAIL done_unexpected: got done with red_cnt=%0d, required none", red_cnt);
      end else begin
        e_cnt = exp_done.pop_front();
        if (red_cnt !== e_cnt) begin
          errors++;
          $display("FAIL done_red_cnt: got %0d, required %0d", red_cnt, e_cnt);
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge Clock);
    Reset = 1'b1; stk_clr = 1'b1; force_full = 1'b0; rd_ready = 1'b1; in_valid = 1'b0;
    @(negedge Clock);
    Reset = 1'b0; stk_clr = 1'b0;
  endtask

  task automatic send(input logic [2:0] op, output bit ok);
    int n = 0;
    @(negedge Clock);
    while (!in_ready && n < 100) begin
      @(negedge Clock);
      n++;
    end
    ok = in_ready;
    if (ok) begin
      in_valid = 1'b1; in_op = op; acc_cyc = cyc;
      @(posedge Clock);
      #1;
      in_valid = 1'b0; in_op = 3'd0;
    end
  endtask

  task automatic settle(output bit ok);
    int n = 0;
    @(negedge Clock);
    while (!(in_ready || err) && n < 100) begin
      @(negedge Clock);
      n++;
    end
    ok = in_ready || err;
  endtask

  task automatic run(input logic [2:0] op, input string name);
    bit ok;
    send(op, ok);
    if (ok) settle(ok);
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $display("FAIL %s_timeout: got no return to IDLE/ERR, required within 100 cycles", name);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge Clock);
    Reset = 1'b0; stk_clr = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b, required 0", err); end
    checks++; if (red_cnt !== 8'd0) begin errors++; $display("FAIL reset_red_cnt: got %0d, required 0", red_cnt); end
    checks++; if (rd_op !== 3'd0) begin errors++; $display("FAIL reset_rd_op: got %0d, required 0", rd_op); end
    checks++;
    if ({op_push, op_pop, rd_valid, done} !== 4'b0) begin
      errors++;
      $display("FAIL reset_strobes: got %b, required 0000", {op_push, op_pop, rd_valid, done});
    end
  endtask

  task automatic test_basic();
    int p0;
    do_reset();
    p0 = obs_pops;
    exp_push.push_back(AD);
    run(AD, "basic_ad");
    checks++;
    if (last_push_cyc - acc_cyc !== 2) begin
      errors++;
      $display("FAIL push_latency: got %0d cycles after accept, required 2", last_push_cyc - acc_cyc);
    end
    exp_push.push_back(ML);
    run(ML, "basic_ml");
    exp_rd.push_back(ML); exp_rd.push_back(AD); exp_done.push_back(8'd2);
    run(EN, "basic_end");
    checks++; if (obs_pops - p0 !== 2) begin errors++; $display("FAIL basic_pops: got %0d, required 2", obs_pops - p0); end
    checks++; if (sp !== 4'd0) begin errors++; $display("FAIL basic_depth: got %0d, required 0", sp); end
    checks++; if (red_cnt !== 8'd0) begin errors++; $display("FAIL basic_cnt_clear: got %0d, required 0", red_cnt); end
    checks++;
    if (exp_push.size() + exp_rd.size() + exp_done.size() !== 0) begin
      errors++;
      $display("FAIL basic_drain: got %0d events outstanding, required 0", exp_push.size() + exp_rd.size() + exp_done.size());
    end
  endtask

  task automatic test_reduce_lower();
    do_reset();
    exp_push.push_back(ML);
    run(ML, "lower_ml");
    exp_rd.push_back(ML); exp_push.push_back(AD);
    run(AD, "lower_ad");
    checks++; if (sp !== 4'd1) begin errors++; $display("FAIL lower_depth: got %0d, required 1", sp); end
    checks++; if (mem[0] !== AD) begin errors++; $display("FAIL lower_top: got %0d, required %0d", mem[0], AD); end
    checks++; if (red_cnt !== 8'd1) begin errors++; $display("FAIL lower_cnt: got %0d, required 1", red_cnt); end
    exp_rd.push_back(AD); exp_done.push_back(8'd2);
    run(EN, "lower_end");
    checks++;
    if (exp_push.size() + exp_rd.size() + exp_done.size() !== 0) begin
      errors++;
      $display("FAIL lower_drain: got %0d events outstanding, required 0", exp_push.size() + exp_rd.size() + exp_done.size());
    end
  endtask

  task automatic test_right_assoc();
    do_reset();
    exp_push.push_back(PW);
    run(PW, "rassoc_pw1");
    exp_push.push_back(PW);
    run(PW, "rassoc_pw2");
    checks++; if (sp !== 4'd2) begin errors++; $display("FAIL rassoc_depth: got %0d, required 2", sp); end
    exp_rd.push_back(PW); exp_rd.push_back(PW); exp_done.push_back(8'd2);
    run(EN, "rassoc_end");
    checks++;
    if (exp_push.size() + exp_rd.size() + exp_done.size() !== 0) begin
      errors++;
      $display("FAIL rassoc_drain: got %0d events outstanding, required 0", exp_push.size() + exp_rd.size() + exp_done.size());
    end
  endtask

  task automatic test_parens();
    int p0;
    do_reset();
    p0 = obs_pops;
    exp_push.push_back(LP); run(LP, "paren_lp");
    exp_push.push_back(AD); run(AD, "paren_ad");
    exp_rd.push_back(AD);   run(RP, "paren_rp");
    checks++; if (obs_pops - p0 !== 2) begin errors++; $display("FAIL paren_pops: got %0d, required 2", obs_pops - p0); end
    checks++; if (sp !== 4'd0) begin errors++; $display("FAIL paren_depth: got %0d, required 0", sp); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL paren_idle: got in_ready=%b, required 1", in_ready); end
    exp_done.push_back(8'd1);
    run(EN, "paren_end");
    checks++;
    if (exp_push.size() + exp_rd.size() + exp_done.size() !== 0) begin
      errors++;
      $display("FAIL paren_drain: got %0d events outstanding, required 0", exp_push.size() + exp_rd.size() + exp_done.size());
    end
  endtask

  task automatic test_errors();
    // RP that runs the stack dry while reducing
    do_reset();
    exp_push.push_back(ML); run(ML, "err_ml");
    exp_rd.push_back(ML); exp_push.push_back(AD); run(AD, "err_ad");
    exp_rd.push_back(AD); run(RP, "err_rp");
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_rp_empty: got err=%b, required 1", err); end
    checks++; if (red_cnt !== 8'd2) begin errors++; $display("FAIL err_cnt: got %0d, required 2", red_cnt); end
    @(negedge Clock); in_valid = 1'b1; in_op = AD;
    repeat (4) @(negedge Clock);
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: got in_ready=%b err=%b, required 0 1", in_ready, err);
    end
    do_reset();
    checks++;
    if (err !== 1'b0 || red_cnt !== 8'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL err_reset_clear: got err=%b red_cnt=%0d in_ready=%b, required 0 0 1", err, red_cnt, in_ready);
    end
    // END with LP on top
    exp_push.push_back(LP); run(LP, "err_lp");
    run(EN, "err_end");
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_end_lp: got err=%b, required 1", err); end
    // push while full
    do_reset();
    exp_push.push_back(AD); run(AD, "err_full_ad");
    force_full = 1'b1;
    run(ML, "err_full_ml");
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_full: got err=%b, required 1", err); end
    checks++; if (sp !== 4'd1) begin errors++; $display("FAIL err_full_depth: got %0d, required 1", sp); end
    do_reset();
    checks++;
    if (exp_push.size() + exp_rd.size() + exp_done.size() !== 0) begin
      errors++;
      $display("FAIL err_drain: got %0d events outstanding, required 0", exp_push.size() + exp_rd.size() + exp_done.size());
    end
  endtask

  task automatic test_stall_reset();
    int p0;
    int n;
    bit ok;
    do_reset();
    exp_push.push_back(ML); run(ML, "stall_ml");
    rd_ready = 1'b0;
    p0 = obs_pops;
    send(AD, ok);
    n = 0;
    @(negedge Clock);
    while (!rd_valid && n < 20) begin
      @(negedge Clock);
      n++;
    end
    checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL stall_enter: got rd_valid=%b, required 1", rd_valid); end
    for (int i = 0; i < 5; i++) begin
      @(negedge Clock);
      checks++;
      if (rd_valid !== 1'b1 || rd_op !== ML || op_pop !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold: got rd_valid=%b rd_op=%0d op_pop=%b, required 1 %0d 0", rd_valid, rd_op, op_pop, ML);
      end
    end
    Reset = 1'b1;
    @(posedge Clock);
    #1;
    checks++;
    if (in_ready !== 1'b1 || rd_valid !== 1'b0 || rd_op !== 3'd0 || op_pop !== 1'b0) begin
      errors++;
      $display("FAIL stall_reset: got in_ready=%b rd_valid=%b rd_op=%0d op_pop=%b, required 1 0 0 0", in_ready, rd_valid, rd_op, op_pop);
    end
    @(negedge Clock);
    Reset = 1'b0; rd_ready = 1'b1;
    repeat (3) @(negedge Clock);
    checks++; if (obs_pops - p0 !== 0) begin errors++; $display("FAIL stall_pops: got %0d, required 0", obs_pops - p0); end
    checks++; if (sp !== 4'd1) begin errors++; $display("FAIL stall_depth: got %0d, required 1", sp); end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reduce_lower();
    test_right_assoc();
    test_parens();
    test_errors();
    test_stall_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
